txline_pulse_rx: RTL and testbench

- Far-end receiver for the transmission-line/channel link. It is the counterpart of the bench pulse driver, which sends current pulses through the txline and channel models.
- Samples the received channel voltage once per clock and slices it with hysteresis into a logic level.
- Measures the width of each high pulse and the period between rising edges, and counts pulses.
- Flags width violations and a stuck-high line, so benches can check link integrity digitally instead of only by waveform probe.

---
 rtl/txline_pulse_rx.sv | 178 +++++++++++++++++
 tb/tb_txline_pulse_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/txline_pulse_rx.sv
// ---------------------------------------------------------------------------
// txline_pulse_rx -- far-end receiver for the transmission-line/channel link.
//
// Slices the received channel voltage with hysteresis into a logic level. It
// then measures the width of each high pulse and the period between rising
// edges, and counts completed pulses. It also flags pulses that are too short
// or too long, and a line that stays high for too long.
//
// Ports:
//   clk          in   sampling clock, all state changes on the rising edge
//   rstn         in   asynchronous active-low reset
//   vin          in   received channel voltage (real), sampled every edge
//   clr          in   synchronous clear of pulse_cnt and the period history
//   level        out  sliced, hysteresis-filtered line level
//   pulse_valid  out  1-cycle strobe: a pulse has completed
//   pulse_width  out  width of the last completed pulse in clocks (held)
//   width_err    out  with pulse_valid: width < MIN_W or width > MAX_W
//   period_valid out  1-cycle strobe: a rise with a known previous rise
//   period       out  clocks between the last two rising edges (held)
//   pulse_cnt    out  completed pulses, saturating
//   stuck        out  line high for more than MAX_W clocks
// ---------------------------------------------------------------------------
module txline_pulse_rx #(
  parameter real VTH_HI = 0.1,
  parameter real VTH_LO = -0.1,
  parameter int  WW     = 8,
  parameter int  CW     = 16,
  parameter int  MIN_W  = 2,
  parameter int  MAX_W  = 20
) (
  input  logic          clk,
  input  logic          rstn,
  input  real           vin,
  input  logic          clr,
  output logic          level,
  output logic          pulse_valid,
  output logic [WW-1:0] pulse_width,
  output logic          width_err,
  output logic          period_valid,
  output logic [WW-1:0] period,
  output logic [CW-1:0] pulse_cnt,
  output logic          stuck
);

  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_SAT = {WW{1'b1}};
  localparam logic [WW-1:0] MIN_C = WW'(MIN_W);
  localparam logic [WW-1:0] MAX_C = WW'(MAX_W);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_SAT = {CW{1'b1}};

  typedef enum logic {ST_LOW, ST_HIGH} state_t;

  state_t        state_q;
  logic          level_q;
  logic          level_d;
  logic [WW-1:0] wcnt_q;
  logic [WW-1:0] wcnt_d;
  logic [WW-1:0] pcnt_q;
  logic [WW-1:0] pcnt_d;
  logic [CW-1:0] cnt_d;
  logic          seen_first_q;
  // sampled_q: the slicer has taken at least one real sample since reset.
  // armed_q:   the FSM has seen a genuine low since reset.
  logic          sampled_q;
  logic          armed_q;
  logic          pulse_valid_q;
  logic [WW-1:0] pulse_width_q;
  logic          width_err_q;
  logic          period_valid_q;
  logic [WW-1:0] period_q;
  logic [CW-1:0] pulse_cnt_q;
  logic          stuck_q;

  // Slicer with hysteresis; a voltage exactly on a threshold holds the level.
  always_comb begin
    level_d = level_q;
    if (vin > VTH_HI) begin
      level_d = 1'b1;
    end else if (vin < VTH_LO) begin
      level_d = 1'b0;
    end
  end

  // Saturating increments of the width, period and pulse counters.
  always_comb begin
    wcnt_d = (wcnt_q == W_SAT) ? wcnt_q : wcnt_q + W_ONE;
    pcnt_d = (pcnt_q == W_SAT) ? pcnt_q : pcnt_q + W_ONE;
    cnt_d  = (pulse_cnt_q == C_SAT) ? pulse_cnt_q : pulse_cnt_q + C_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_LOW;
      level_q        <= 1'b0;
      wcnt_q         <= '0;
      pcnt_q         <= '0;
      seen_first_q   <= 1'b0;
      sampled_q      <= 1'b0;
      armed_q        <= 1'b0;
      pulse_valid_q  <= 1'b0;
      pulse_width_q  <= '0;
      width_err_q    <= 1'b0;
      period_valid_q <= 1'b0;
      period_q       <= '0;
      pulse_cnt_q    <= '0;
      stuck_q        <= 1'b0;
    end else begin
      level_q        <= level_d;
      sampled_q      <= 1'b1;
      pulse_valid_q  <= 1'b0;
      width_err_q    <= 1'b0;
      period_valid_q <= 1'b0;
      pcnt_q         <= pcnt_d;

      // A line that is already high when reset releases is the tail of a
      // pulse whose start was lost. It must not be reported as a pulse or
      // used as a period reference. Rises are therefore ignored until the
      // FSM has seen a low that came from a real sample rather than from the
      // reset value of level_q.
      if (sampled_q && !level_q) begin
        armed_q <= 1'b1;
      end

      // The clear comes first so that a rise on the same edge still leaves
      // seen_first set by the assignment in the case statement below.
      if (clr) begin
        seen_first_q <= 1'b0;
      end

      case (state_q)
        ST_LOW: begin
          if (level_q && armed_q) begin
            state_q <= ST_HIGH;
            wcnt_q  <= W_ONE;
            if (seen_first_q && !clr) begin
              period_q       <= pcnt_q;
              period_valid_q <= 1'b1;
            end
            pcnt_q       <= W_ONE;
            seen_first_q <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (level_q) begin
            wcnt_q <= wcnt_d;
            if (wcnt_d > MAX_C) begin
              stuck_q <= 1'b1;
            end
          end else begin
            state_q       <= ST_LOW;
            pulse_valid_q <= 1'b1;
            pulse_width_q <= wcnt_q;
            width_err_q   <= (wcnt_q < MIN_C) || (wcnt_q > MAX_C);
            pulse_cnt_q   <= cnt_d;
            stuck_q       <= 1'b0;
          end
        end
        default: state_q <= ST_LOW;
      endcase

      // The clear wins over a pulse completing on the same edge.
      if (clr) begin
        pulse_cnt_q <= '0;
      end
    end
  end

  assign level        = level_q;
  assign pulse_valid  = pulse_valid_q;
  assign pulse_width  = pulse_width_q;
  assign width_err    = width_err_q;
  assign period_valid = period_valid_q;
  assign period       = period_q;
  assign pulse_cnt    = pulse_cnt_q;
  assign stuck        = stuck_q;

endmodule

// File: tb/tb_txline_pulse_rx.sv
// ---------------------------------------------------------------------------
// tb_txline_pulse_rx -- directed, table-driven bench for txline_pulse_rx.
// A default instance is checked in full. A second instance with CW=2 shares
// the stimulus and is used for the pulse counter saturation checks.
// ---------------------------------------------------------------------------
module tb_txline_pulse_rx;

  logic        clk;
  logic        rstn;
  logic        clr;
  real         vin;

  logic        level, pulse_valid, width_err, period_valid, stuck;
  logic [7:0]  pulse_width, period;
  logic [15:0] pulse_cnt;

  logic        s_level, s_pulse_valid, s_width_err, s_period_valid, s_stuck;
  logic [7:0]  s_pulse_width, s_period;
  logic [1:0]  s_pulse_cnt;

  txline_pulse_rx dut (
    .clk(clk), .rstn(rstn), .vin(vin), .clr(clr),
    .level(level), .pulse_valid(pulse_valid), .pulse_width(pulse_width),
    .width_err(width_err), .period_valid(period_valid), .period(period),
    .pulse_cnt(pulse_cnt), .stuck(stuck)
  );

  txline_pulse_rx #(.CW(2)) dut2 (
    .clk(clk), .rstn(rstn), .vin(vin), .clr(clr),
    .level(s_level), .pulse_valid(s_pulse_valid), .pulse_width(s_pulse_width),
    .width_err(s_width_err), .period_valid(s_period_valid), .period(s_period),
    .pulse_cnt(s_pulse_cnt), .stuck(s_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge away from the active edge.
  int         n_pv, n_perv, n_orphan, n_both, n_stuck, n_lvl;
  logic [7:0] cap_w, cap_p;
  logic       cap_err;

  initial begin
    n_pv = 0; n_perv = 0; n_orphan = 0; n_both = 0; n_stuck = 0; n_lvl = 0;
    cap_w = '0; cap_p = '0; cap_err = 1'b0;
  end

  always @(negedge clk) begin
    if (pulse_valid) begin
      n_pv    = n_pv + 1;
      cap_w   = pulse_width;
      cap_err = width_err;
    end
    if (period_valid) begin
      n_perv = n_perv + 1;
      cap_p  = period;
    end
    if (width_err && !pulse_valid) n_orphan = n_orphan + 1;
    if (pulse_valid && period_valid) n_both = n_both + 1;
    if (stuck) n_stuck = n_stuck + 1;
    if (level) n_lvl = n_lvl + 1;
  end

  int n_checks;
  int n_err;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Hold vin at mv millivolts for n rising edges; returns just after an edge.
  task automatic drive(input int mv, input int n);
    vin = mv / 1000.0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " level"}, level, 0);
    check({tag, " pulse_valid"}, pulse_valid, 0);
    check({tag, " pulse_width"}, pulse_width, 0);
    check({tag, " width_err"}, width_err, 0);
    check({tag, " period_valid"}, period_valid, 0);
    check({tag, " period"}, period, 0);
    check({tag, " pulse_cnt"}, pulse_cnt, 0);
    check({tag, " stuck"}, stuck, 0);
  endtask

  typedef struct {
    int hi;      // high clocks
    int lo;      // low clocks
    int vh_mv;   // high voltage, mV
    int vl_mv;   // low voltage, mV
    int w;       // expected pulse_width
    int err;     // expected width_err
    int nper;    // expected period_valid strobes in this record
    int per;     // expected period when nper = 1
    int nstuck;  // expected cycles with stuck high
  } rec_t;

  rec_t tbl[8];

  // Timeout guard; the directed sequence finishes long before this.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int b_pv, b_perv, b_st, b_lvl;

    // Periods are rise-to-rise: the previous record's hi + lo.
    tbl[0] = '{5,  15, 350,  -350, 5,  0, 0, 0,  0};
    tbl[1] = '{5,  15, 350,  -350, 5,  0, 1, 20, 0};
    tbl[2] = '{5,  15, 350,  -350, 5,  0, 1, 20, 0};
    tbl[3] = '{5,  15, 350,  -350, 5,  0, 1, 20, 0};
    tbl[4] = '{1,  10, 110,  -110, 1,  1, 1, 20, 0};
    tbl[5] = '{21, 10, 500,  -200, 21, 1, 1, 11, 1};
    tbl[6] = '{20, 10, 350,  -350, 20, 0, 1, 31, 0};
    tbl[7] = '{2,  5,  200,  -500, 2,  0, 1, 30, 0};

    n_checks = 0;
    n_err    = 0;
    rstn     = 1'b0;
    clr      = 1'b0;
    vin      = 0.0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // Glitch immunity: 0.05 V never crosses the upper threshold.
    b_pv = n_pv; b_perv = n_perv; b_lvl = n_lvl;
    drive(0, 10);
    drive(50, 3);
    drive(0, 3);
    check("glitch level", n_lvl - b_lvl, 0);
    check("glitch pulse_valid", n_pv - b_pv, 0);
    check("glitch period_valid", n_perv - b_perv, 0);
    check("glitch pulse_cnt", pulse_cnt, 0);
    $display("glitch: level_high_cycles=%0d pulses=%0d", n_lvl - b_lvl, n_pv - b_pv);

    // Table of pulses: nominal, width bounds and stuck detection.
    for (int i = 0; i < 8; i++) begin
      b_pv = n_pv; b_perv = n_perv; b_st = n_stuck;
      drive(tbl[i].vh_mv, tbl[i].hi);
      drive(tbl[i].vl_mv, tbl[i].lo);
      check($sformatf("rec%0d pulse_valid count", i), n_pv - b_pv, 1);
      check($sformatf("rec%0d pulse_width", i), cap_w, tbl[i].w);
      check($sformatf("rec%0d width_err", i), cap_err, tbl[i].err);
      check($sformatf("rec%0d period_valid count", i), n_perv - b_perv, tbl[i].nper);
      if (tbl[i].nper == 1) check($sformatf("rec%0d period", i), cap_p, tbl[i].per);
      check($sformatf("rec%0d stuck cycles", i), n_stuck - b_st, tbl[i].nstuck);
      check($sformatf("rec%0d stuck after fall", i), stuck, 0);
      check($sformatf("rec%0d pulse_cnt", i), pulse_cnt, i + 1);
      check($sformatf("rec%0d cw2 pulse_cnt", i), s_pulse_cnt, (i + 1 > 3) ? 3 : i + 1);
      $display("rec%0d: hi=%0d lo=%0d width=%0d err=%0d periods=%0d period=%0d cnt=%0d",
               i, tbl[i].hi, tbl[i].lo, cap_w, cap_err, n_perv - b_perv, cap_p, pulse_cnt);
    end

    // Minimal legal sequence: strobes alternate and never coincide.
    b_pv = n_pv; b_perv = n_perv;
    repeat (4) begin
      drive(350, 1);
      drive(-350, 1);
    end
    drive(-350, 4);
    check("minimal pulse_valid count", n_pv - b_pv, 4);
    check("minimal period_valid count", n_perv - b_perv, 4);
    check("minimal width", cap_w, 1);
    check("minimal width_err", cap_err, 1);
    check("minimal period", cap_p, 2);
    check("minimal pulse_cnt", pulse_cnt, 12);
    $display("minimal: pulses=%0d periods=%0d period=%0d", n_pv - b_pv, n_perv - b_perv, cap_p);

    // Hysteresis ramp, -0.30 V to +0.30 V and back in 0.05 V steps.
    drive(-300, 2);
    b_pv = n_pv;
    for (int k = -6; k <= 6; k++) begin
      vin = k / 20.0;
      @(posedge clk);
      #1;
      check($sformatf("ramp up k=%0d level", k), level, (k >= 3) ? 1 : 0);
    end
    for (int k = 5; k >= -6; k--) begin
      vin = k / 20.0;
      @(posedge clk);
      #1;
      check($sformatf("ramp down k=%0d level", k), level, (k > -3) ? 1 : 0);
    end
    drive(-300, 4);
    check("ramp pulse_valid count", n_pv - b_pv, 1);
    check("ramp pulse_width", cap_w, 12);
    check("ramp pulse_cnt", pulse_cnt, 13);
    $display("ramp: width=%0d cnt=%0d", cap_w, pulse_cnt);

    // clr on the edge where the FSM sees the rise.
    b_pv = n_pv; b_perv = n_perv;
    vin = 0.35;
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr pulse_cnt", pulse_cnt, 0);
    check("clr period_valid count", n_perv - b_perv, 0);
    drive(350, 2);
    drive(-350, 8);
    check("clr pulse completes", n_pv - b_pv, 1);
    check("clr pulse width", cap_w, 4);
    check("clr pulse_cnt after", pulse_cnt, 1);
    drive(350, 4);
    drive(-350, 8);
    check("clr next period_valid count", n_perv - b_perv, 1);
    check("clr next period", cap_p, 12);
    check("clr next pulse_cnt", pulse_cnt, 2);
    $display("clr: periods=%0d period=%0d cnt=%0d", n_perv - b_perv, cap_p, pulse_cnt);

    // Reset during clk 3 of a 6-clk pulse.
    vin = 0.35;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    b_pv = n_pv; b_perv = n_perv;
    drive(350, 2);
    drive(-350, 10);
    check("midreset tail pulse_valid", n_pv - b_pv, 0);
    check("midreset tail pulse_cnt", pulse_cnt, 0);
    drive(350, 5);
    drive(-350, 10);
    check("midreset next pulse_valid", n_pv - b_pv, 1);
    check("midreset next width", cap_w, 5);
    check("midreset next period_valid", n_perv - b_perv, 0);
    check("midreset next pulse_cnt", pulse_cnt, 1);
    $display("midreset: width=%0d periods=%0d cnt=%0d", cap_w, n_perv - b_perv, pulse_cnt);

    // Four more pulses: the CW=2 counter saturates at 3.
    repeat (4) begin
      drive(350, 3);
      drive(-350, 5);
    end
    check("sat pulse_cnt", pulse_cnt, 5);
    check("sat cw2 pulse_cnt", s_pulse_cnt, 3);
    check("sat period_valid count", n_perv - b_perv, 4);
    check("sat last period", cap_p, 8);
    check("sat last width", cap_w, 3);
    $display("sat: cnt=%0d cw2_cnt=%0d period=%0d", pulse_cnt, s_pulse_cnt, cap_p);

    check("width_err without pulse_valid", n_orphan, 0);
    check("pulse_valid with period_valid", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
